// File: rtl/bundle_sequencer.sv
// Bundle fetch/issue sequencer: prefetches NFU-slot instruction bundles into a small queue
// and issues them one at a time to the functional units, with branch redirect support.
module bundle_sequencer #(
  parameter int unsigned NFU      = 2,
  parameter int unsigned QDEPTH   = 4,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                        clk,
  input  logic                        rst,
  output logic                        fetchReq,
  output logic [63:0]                 fetchAddr,
  input  logic                        fetchDone,
  input  logic [NFU*32-1:0]           fetchData,
  output logic                        issueValid,
  output logic [NFU*32-1:0]           issueBundle,
  output logic [63:0]                 issuePC,
  input  logic [NFU-1:0]              fuWorking,
  input  logic [NFU-1:0]              writePC,
  input  logic [NFU*64-1:0]           newPC,
  output logic [$clog2(QDEPTH):0]     queueCount
);

  localparam int unsigned BW = NFU * 32;
  localparam int unsigned PW = $clog2(QDEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [63:0]   BB    = 64'(NFU * 4);
  localparam logic [CW-1:0] QFULL = CW'(QDEPTH);

  typedef enum logic [0:0] {StIdle, StWait} fetch_st_e;

  fetch_st_e         st_q, st_d;
  logic [63:0]       pc_q, pc_d;
  logic [63:0]       req_addr_q, req_addr_d;
  logic              stale_q, stale_d;
  logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
  logic [CW-1:0]     count_q, count_d;
  logic              iv_q, iv_d;
  logic [BW-1:0]     ib_q, ib_d;
  logic [63:0]       ipc_q, ipc_d;

  logic [63:0]       q_addr [QDEPTH];
  logic [BW-1:0]     q_data [QDEPTH];

  logic              redirect, found, push, pop;
  logic [63:0]       target;

  // Lowest-index FU wins when several request a branch together.
  always_comb begin
    target = '0;
    found  = 1'b0;
    for (int i = 0; i < NFU; i++) begin
      if (writePC[i] && !found) begin
        target = newPC[64*i +: 64];
        found  = 1'b1;
      end
    end
  end

  assign redirect = |writePC;
  assign push = (st_q == StWait) && fetchDone && !stale_q && !redirect && (count_q != QFULL);
  assign pop  = (count_q != '0) && (fuWorking == '0) && !redirect && !iv_q;

  always_comb begin
    st_d       = st_q;
    pc_d       = pc_q;
    req_addr_d = req_addr_q;
    stale_d    = stale_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    iv_d       = pop;
    ib_d       = ib_q;
    ipc_d      = ipc_q;

    if (pop) begin
      ib_d   = q_data[head_q];
      ipc_d  = q_addr[head_q];
      head_d = head_q + 1'b1;
    end
    if (push) begin
      tail_d = tail_q + 1'b1;
      pc_d   = req_addr_q + BB;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (redirect) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      pc_d    = target;
    end

    // A slot is reserved when a fetch is launched, so the queue can never overflow on push.
    unique case (st_q)
      StIdle: begin
        if (!redirect && (count_q < QFULL)) begin
          st_d       = StWait;
          req_addr_d = pc_q;
        end
      end
      StWait: begin
        if (fetchDone) begin
          st_d    = StIdle;
          stale_d = 1'b0;
        end else if (redirect) begin
          stale_d = 1'b1;
        end
      end
      default: st_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q       <= StIdle;
      pc_q       <= RESET_PC;
      req_addr_q <= '0;
      stale_q    <= 1'b0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      iv_q       <= 1'b0;
      ib_q       <= '0;
      ipc_q      <= '0;
    end else begin
      st_q       <= st_d;
      pc_q       <= pc_d;
      req_addr_q <= req_addr_d;
      stale_q    <= stale_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      iv_q       <= iv_d;
      ib_q       <= ib_d;
      ipc_q      <= ipc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_addr[tail_q] <= req_addr_q;
      q_data[tail_q] <= fetchData;
    end
  end

  assign fetchReq    = (st_q == StWait);
  assign fetchAddr   = req_addr_q;
  assign issueValid  = iv_q;
  assign issueBundle = ib_q;
  assign issuePC     = ipc_q;
  assign queueCount  = count_q;

endmodule

// File: tb/tb_bundle_sequencer.sv
// Directed and randomized checks of bundle_sequencer against an in-order issue model.
module tb_bundle_sequencer;
  localparam int unsigned NFU = 2;
  localparam int unsigned QDEPTH = 4;
  localparam logic [63:0] RESET_PC = 64'h1000;
  localparam logic [63:0] BB = 64'd8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 fetchReq;
  logic [63:0]          fetchAddr;
  logic                 fetchDone = 1'b0;
  logic [NFU*32-1:0]    fetchData = '0;
  logic                 issueValid;
  logic [NFU*32-1:0]    issueBundle;
  logic [63:0]          issuePC;
  logic [NFU-1:0]       fuWorking = '0;
  logic [NFU-1:0]       writePC = '0;
  logic [NFU*64-1:0]    newPC = '0;
  logic [$clog2(QDEPTH):0] queueCount;

  bundle_sequencer #(.NFU(NFU), .QDEPTH(QDEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst(rst), .fetchReq(fetchReq), .fetchAddr(fetchAddr),
    .fetchDone(fetchDone), .fetchData(fetchData), .issueValid(issueValid),
    .issueBundle(issueBundle), .issuePC(issuePC), .fuWorking(fuWorking),
    .writePC(writePC), .newPC(newPC), .queueCount(queueCount)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int lat = 0;
  int wait_cnt = 0;
  int n_issue = 0;
  logic [63:0] exp_pc;
  bit prev_iv, prev_req;
  logic [63:0] prev_addr;
  logic [63:0] q_req[$];

  // Memory contents are a fixed function of the address, so any bundle can be predicted.
  function automatic logic [NFU*32-1:0] fdata(input logic [63:0] a);
    return {~a[31:0], a[31:0] ^ 32'h5A5A_0000};
  endfunction

  function automatic logic [63:0] pick_target(input logic [NFU-1:0] w, input logic [NFU*64-1:0] p);
    for (int i = 0; i < NFU; i++) if (w[i]) return p[64*i +: 64];
    return 64'h0;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_pc = RESET_PC;
    prev_iv = 1'b0;
    prev_req = 1'b0;
    prev_addr = '0;
    wait_cnt = 0;
  endtask

  // One clock: memory responder, edge, then scoreboard checks 1 time unit after the edge.
  task automatic tick();
    logic redir, done_drv;
    logic [63:0] tgt;
    if (fetchReq) begin
      if (wait_cnt >= lat) begin
        fetchDone = 1'b1;
        fetchData = fdata(fetchAddr);
        wait_cnt = 0;
      end else begin
        fetchDone = 1'b0;
        wait_cnt++;
      end
    end else begin
      fetchDone = 1'b0;
    end
    redir = |writePC;
    tgt = pick_target(writePC, newPC);
    done_drv = fetchDone;
    @(posedge clk);
    #1;
    writePC = '0;
    if (redir) begin
      exp_pc = tgt;
      check("issue_suppressed", 64'(issueValid), 64'd0);
      check("redirect_flush", 64'(queueCount), 64'd0);
    end else if (issueValid) begin
      check("issue_pc", issuePC, exp_pc);
      check("issue_bundle", 64'(issueBundle), 64'(fdata(exp_pc)));
      exp_pc = exp_pc + BB;
      n_issue++;
    end
    check("issue_spacing", 64'(issueValid && prev_iv), 64'd0);
    check("count_bound", 64'(queueCount <= QDEPTH), 64'd1);
    if (prev_req && !done_drv) begin
      check("req_hold", 64'(fetchReq), 64'd1);
      check("addr_hold", fetchAddr, prev_addr);
    end
    if (prev_req && done_drv) check("req_drop", 64'(fetchReq), 64'd0);
    if (!prev_req && fetchReq) q_req.push_back(fetchAddr);
    prev_iv = issueValid;
    prev_req = fetchReq;
    prev_addr = fetchAddr;
  endtask

  initial begin
    int base, guard, n0;
    logic ok;

    // Reset state
    rst = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_fetchReq", 64'(fetchReq), 64'd0);
    check("rst_issueValid", 64'(issueValid), 64'd0);
    check("rst_issuePC", issuePC, 64'd0);
    check("rst_queueCount", 64'(queueCount), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // First fetch, one-cycle memory, issue latency
    tick();
    check("first_req", 64'(fetchReq), 64'd1);
    check("first_addr", fetchAddr, RESET_PC);
    tick();
    check("after_done_count", 64'(queueCount), 64'd1);
    tick();
    check("first_issue_valid", 64'(issueValid), 64'd1);
    check("first_issue_pc", issuePC, 64'h1000);
    check("second_addr", fetchAddr, 64'h1008);

    // Busy FUs: queue fills to QDEPTH and fetching stops
    fuWorking = 2'b11;
    guard = 0;
    while (!(queueCount == QDEPTH && !fetchReq) && guard < 40) begin tick(); guard++; end
    check("fill_count", 64'(queueCount), 64'(QDEPTH));
    check("req_seq0", q_req[0], 64'h1000);
    check("req_seq1", q_req[1], 64'h1008);
    check("req_seq2", q_req[2], 64'h1010);
    repeat (4) begin
      tick();
      check("full_no_req", 64'(fetchReq), 64'd0);
      check("full_count", 64'(queueCount), 64'(QDEPTH));
    end
    fuWorking = '0;
    base = n_issue;
    n0 = q_req.size();
    repeat (12) tick();
    check("resume_issue", 64'(n_issue - base >= 4), 64'd1);
    check("resume_fetch", 64'(q_req.size() > n0), 64'd1);

    // Multi-FU redirect priority
    fuWorking = 2'b11;
    guard = 0;
    while (!(queueCount == QDEPTH && !fetchReq) && guard < 40) begin tick(); guard++; end
    check("refill_count", 64'(queueCount), 64'(QDEPTH));
    writePC = 2'b11;
    newPC = {64'h3000, 64'h2000};
    tick();
    check("redir_idle_no_req", 64'(fetchReq), 64'd0);
    tick();
    check("redir_req", 64'(fetchReq), 64'd1);
    check("redir_addr", fetchAddr, 64'h2000);

    // Asynchronous reset in the middle of a fetch
    lat = 100;
    tick();
    #3;
    rst = 1'b0;
    #1;
    check("arst_fetchReq", 64'(fetchReq), 64'd0);
    check("arst_fetchAddr", fetchAddr, 64'd0);
    check("arst_issueValid", 64'(issueValid), 64'd0);
    check("arst_issuePC", issuePC, 64'd0);
    check("arst_issueBundle", 64'(issueBundle), 64'd0);
    check("arst_queueCount", 64'(queueCount), 64'd0);
    fetchDone = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    lat = 0;
    tick();
    check("post_rst_req", 64'(fetchReq), 64'd1);
    check("post_rst_addr", fetchAddr, RESET_PC);

    // Redirect while 0x1018 is outstanding: its data must be dropped
    guard = 0;
    while (!(fetchReq && fetchAddr == 64'h1018) && guard < 40) begin tick(); guard++; end
    check("reach_1018", fetchAddr, 64'h1018);
    lat = 100;
    writePC = 2'b01;
    newPC = {{$urandom, $urandom}, 64'h4000};
    tick();
    check("stale_hold_req", 64'(fetchReq), 64'd1);
    check("stale_hold_addr", fetchAddr, 64'h1018);
    lat = 0;
    tick();
    check("stale_done_count", 64'(queueCount), 64'd0);
    tick();
    check("stale_next_req", 64'(fetchReq), 64'd1);
    check("stale_next_addr", fetchAddr, 64'h4000);
    fuWorking = '0;
    base = n_issue;
    repeat (10) tick();
    check("post_stale_issue", 64'(n_issue - base >= 2), 64'd1);

    // Randomized traffic
    base = n_issue;
    repeat (600) begin
      fuWorking = ($urandom_range(0, 2) == 0) ? 2'($urandom) : 2'b00;
      lat = $urandom_range(0, 3);
      if ($urandom_range(0, 19) == 0) begin
        writePC = 2'($urandom_range(1, 3));
        newPC = {{$urandom, $urandom} & ~64'h7, {$urandom, $urandom} & ~64'h7};
      end
      tick();
    end
    check("random_issue_progress", 64'(n_issue - base > 20), 64'd1);

    // Fetch PC wraps at the top of the address space
    fuWorking = 2'b11;
    lat = 0;
    writePC = 2'b01;
    newPC = {64'h0, 64'hFFFF_FFFF_FFFF_FFF8};
    tick();
    n0 = q_req.size();
    repeat (12) tick();
    ok = q_req.size() >= n0 + 2;
    check("wrap_reqs_seen", 64'(ok), 64'd1);
    if (ok) begin
      check("wrap_addr_top", q_req[n0], 64'hFFFF_FFFF_FFFF_FFF8);
      check("wrap_addr_zero", q_req[n0+1], 64'h0);
    end
    fuWorking = '0;
    base = n_issue;
    repeat (10) tick();
    check("wrap_issue", 64'(n_issue - base >= 2), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
